// File: rtl/avg8_seq_ctrl.sv
// Sequential 8-operand averager: one shared adder accumulates the operands,
// one shared shifter applies the shift passes, then the result is held on a valid/ready port.
module avg8_seq_ctrl #(
    parameter int unsigned DATAWIDTH  = 16,
    parameter int unsigned ACCWIDTH   = 32,
    parameter int unsigned NUM_OPS    = 8,
    parameter int unsigned NUM_SHIFTS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [7:0]           sa,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] avg,
    output logic                 busy
);

    localparam int unsigned OCW = $clog2(NUM_OPS + 1);
    localparam int unsigned SCW = $clog2(NUM_SHIFTS + 1);
    localparam logic [OCW-1:0] LAST_OP = OCW'(NUM_OPS - 1);
    localparam logic [SCW-1:0] LAST_SH = SCW'(NUM_SHIFTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SHIFT,
        OUT
    } state_e;

    state_e                 state_q;
    logic [ACCWIDTH-1:0]    acc_q;
    logic [OCW-1:0]         op_cnt_q;
    logic [SCW-1:0]         sh_cnt_q;
    logic [7:0]             sa_q;
    logic [DATAWIDTH-1:0]   avg_q;
    logic                   out_valid_q;

    logic                   accept;
    logic [ACCWIDTH-1:0]    in_ext;
    logic [ACCWIDTH-1:0]    acc_sum;
    logic [ACCWIDTH-1:0]    acc_shr;

    assign in_ready  = rst & ((state_q == IDLE) | (state_q == ACCUM));
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign avg       = avg_q;

    assign accept  = in_valid & in_ready;
    assign in_ext  = ACCWIDTH'(in_data);
    assign acc_sum = acc_q + in_ext;
    // Shift amounts at or beyond the accumulator width flush it to zero.
    assign acc_shr = (32'(sa_q) >= ACCWIDTH) ? '0 : (acc_q >> sa_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_cnt_q    <= '0;
            sh_cnt_q    <= '0;
            sa_q        <= '0;
            avg_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_cnt_q    <= '0;
            sh_cnt_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q    <= in_ext;
                        op_cnt_q <= OCW'(1);
                        state_q  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q    <= acc_sum;
                        op_cnt_q <= op_cnt_q + OCW'(1);
                        if (op_cnt_q == LAST_OP) begin
                            sa_q     <= sa;
                            sh_cnt_q <= '0;
                            state_q  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc_q    <= acc_shr;
                    sh_cnt_q <= sh_cnt_q + SCW'(1);
                    if (sh_cnt_q == LAST_SH) begin
                        avg_q       <= acc_shr[DATAWIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        op_cnt_q    <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avg8_seq_ctrl.sv
// Scoreboard bench for avg8_seq_ctrl: directed scenarios plus randomized
// operand sets checked against an arithmetic reference model.
module tb_avg8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  sa;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] avg;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    avg8_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sa        (sa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .avg       (avg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: sum operands, apply the shift passes, keep the low 16 bits.
    function automatic logic [15:0] model(input logic [15:0] d[8],
                                          input logic [7:0] s);
        longint unsigned sum = 0;
        for (int i = 0; i < 8; i++) sum += d[i];
        sum = sum % (64'd1 << 32);
        for (int k = 0; k < 3; k++) sum = (s >= 32) ? 0 : (sum >> s);
        return sum[15:0];
    endfunction

    // Called aligned to posedge+1; returns at posedge+1 after the accept.
    task automatic send_op(input logic [15:0] d, input int gap);
        bit got = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                got = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!got) fail_now("accept");
    endtask

    task automatic send_set(input logic [15:0] d[8], input int gap,
                            input logic [7:0] s, input bit push);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            sa = (i == 7) ? s : 8'($urandom);
            send_op(d[i], gap);
        end
        if (push) exp_q.push_back(model(d, s));
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("wait_idle");
    endtask

    // Monitor: a result is consumed whenever valid and ready coincide.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                chk("result", 32'(avg), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d[8];
        logic [15:0] seq18[8];
        int hold;
        int gap;
        logic [7:0] s;
        bit got;

        for (int i = 0; i < 8; i++) seq18[i] = 16'(i + 1);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        sa = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avg", 32'(avg), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);

        // 1: operands 1..8, sa=1, latency and in_ready profile
        send_set(seq18, 0, 8'd1, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_shift_out_valid", 32'(out_valid), 0);
            chk("t1_shift_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        chk("t1_latency_out_valid", 32'(out_valid), 1);
        chk("t1_out_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_in_ready", 32'(in_ready), 1);
        chk("t1_avg_kept", 32'(avg), 4);

        // 2: all-ones operands with sa=1 and sa=0
        d = '{default: 16'hFFFF};
        send_set(d, 0, 8'd1, 1);
        send_set(d, 0, 8'd0, 1);
        wait_idle();

        // 3: gaps between operands, sa changed during SHIFT
        send_set(seq18, 2, 8'd1, 1);
        sa = 8'd5;
        wait_idle();

        // 4: consumer backpressure
        out_ready = 1'b0;
        send_set(seq18, 0, 8'd1, 1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_out_valid", 32'(out_valid), 1);
            chk("t4_avg", 32'(avg), 4);
            chk("t4_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
        send_set(d, 1, 8'd2, 1);
        wait_idle();

        // 5: asynchronous reset after four operands
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_op(16'h1234, 0);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_rst_avg", 32'(avg), 0);
        chk("t5_rst_out_valid", 32'(out_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        d = '{default: 16'h0010};
        send_set(d, 0, 8'd2, 1);
        wait_idle();
        chk("t5_avg", 32'(avg), 2);

        // 6: flush during SHIFT, then oversized shift amount
        d = '{default: 16'h0100};
        send_set(d, 0, 8'd1, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("t6_flush_busy", 32'(busy), 0);
        chk("t6_flush_out_valid", 32'(out_valid), 0);
        chk("t6_flush_avg", 32'(avg), 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_out_valid", 32'(out_valid), 0);
        end
        d = '{default: 16'hFFFF};
        send_set(d, 0, 8'd32, 1);
        wait_idle();

        // Randomized sets with random gaps, shifts and backpressure
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
            gap  = $urandom_range(0, 2);
            s    = 8'($urandom_range(0, 40));
            hold = $urandom_range(0, 4);
            out_ready = (hold == 0);
            send_set(d, gap, s, 1);
            if (hold != 0) begin
                got = 0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        got = 1;
                        break;
                    end
                end
                if (!got) fail_now("rand_out_valid");
                repeat (hold) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            wait_idle();
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
